// File: rtl/bp_trace_pkg.sv
// Shared types and defaults for the trace arbiter slice.
package bp_trace_pkg;

    localparam int unsigned TRACE_DATA_W  = 32;
    localparam int unsigned TRACE_NUM_SRC = 2;

    typedef logic [TRACE_DATA_W-1:0]          trace_word_t;
    typedef logic [$clog2(TRACE_NUM_SRC)-1:0] src_id_t;

    // Round-robin successor of grant g among n sources.
    function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
        return (g + 1 == n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/bp_trace_fifo.sv
// Synchronous first-word-fall-through FIFO; a push on full is taken only alongside a pop.
module bp_trace_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr;
    logic             rd;

    assign full_o  = (count == (AW+1)'(DEPTH));
    assign empty_o = (count == '0);
    assign rd      = pop_i & ~empty_o;
    assign wr      = push_i & (~full_o | rd);
    assign data_o  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (wr) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr, rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bp_trace_arbiter.sv
// Merges per-core trace streams through per-source FIFOs into one round-robin
// valid/ready output; overflowing words are dropped and counted, never stalled.
module bp_trace_arbiter
    import bp_trace_pkg::*;
#(
    parameter int unsigned NUM_SRC    = TRACE_NUM_SRC,
    parameter int unsigned DATA_W     = TRACE_DATA_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        enable_i,
    input  logic                        clear_i,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data_i,
    input  logic [NUM_SRC-1:0]          src_valid_i,
    output logic [DATA_W-1:0]           out_data_o,
    output logic [$clog2(NUM_SRC)-1:0]  out_id_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [NUM_SRC-1:0]          overflow_o,
    output logic [NUM_SRC*CNT_W-1:0]    drop_cnt_o
);

    localparam int unsigned ID_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] accept;
    logic [NUM_SRC-1:0] drop;
    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    logic [DATA_W-1:0]  head [NUM_SRC];
    logic               load;
    logic               found;
    logic [ID_W-1:0]    grant;
    logic [ID_W-1:0]    rr;

    assign load = ~out_valid_o | out_ready_i;

    // Two passes: sources at or above rr first, then wrap to the low indices.
    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            if (!found && !empty[s] && (ID_W'(s) >= rr)) begin
                found = 1'b1;
                grant = ID_W'(s);
            end
        end
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            if (!found && !empty[s]) begin
                found = 1'b1;
                grant = ID_W'(s);
            end
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic [CNT_W-1:0] cnt;
        logic             ovf;

        assign push[s]   = src_valid_i[s] & enable_i;
        assign pop[s]    = load & found & (grant == ID_W'(s));
        assign accept[s] = push[s] & (~full[s] | pop[s]);
        assign drop[s]   = push[s] & ~accept[s];

        bp_trace_fifo #(
            .WIDTH (DATA_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .push_i  (accept[s]),
            .pop_i   (pop[s]),
            .data_i  (src_data_i[s*DATA_W +: DATA_W]),
            .data_o  (head[s]),
            .full_o  (full[s]),
            .empty_o (empty[s])
        );

        // A drop in the same cycle as clear restarts the count at one.
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                cnt <= '0;
                ovf <= 1'b0;
            end else if (drop[s]) begin
                ovf <= 1'b1;
                if (clear_i) begin
                    cnt <= CNT_W'(1);
                end else if (cnt != '1) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (clear_i) begin
                cnt <= '0;
                ovf <= 1'b0;
            end
        end

        assign drop_cnt_o[s*CNT_W +: CNT_W] = cnt;
        assign overflow_o[s]                = ovf;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_data_o  <= '0;
            out_id_o    <= '0;
            out_valid_o <= 1'b0;
            rr          <= '0;
        end else if (load) begin
            if (found) begin
                out_data_o  <= head[grant];
                out_id_o    <= grant;
                out_valid_o <= 1'b1;
                rr          <= ID_W'(rr_next(32'(grant), NUM_SRC));
            end else begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bp_trace_arbiter.sv
// Scoreboard bench for bp_trace_arbiter: directed words with hand-ordered expectations.
module tb_bp_trace_arbiter;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic        clear_i;
    logic [63:0] src_data;
    logic [1:0]  src_valid;
    logic [31:0] out_data;
    logic        out_id;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  overflow;
    logic [7:0]  drop_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] expq[$];
    logic [32:0] mon_e;

    bp_trace_arbiter #(
        .NUM_SRC    (2),
        .DATA_W     (32),
        .FIFO_DEPTH (4),
        .CNT_W      (4)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .enable_i    (enable_i),
        .clear_i     (clear_i),
        .src_data_i  (src_data),
        .src_valid_i (src_valid),
        .out_data_o  (out_data),
        .out_id_o    (out_id),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .overflow_o  (overflow),
        .drop_cnt_o  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic id, input logic [31:0] d);
        expq.push_back({id, d});
    endtask

    // Drive one cycle of source inputs; returns 1 time unit after the capturing edge.
    task automatic step(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1);
        src_valid = v;
        src_data  = {d1, d0};
        @(posedge clk);
        #1;
        src_valid = '0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, expq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!reset_i && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got id %0d data 0x%h expected none", out_id, out_data);
            end else begin
                mon_e = expq.pop_front();
                chk("out_id", {31'b0, out_id}, {31'b0, mon_e[32]});
                chk("out_data", out_data, mon_e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset_i   = 1'b1;
        enable_i  = 1'b1;
        clear_i   = 1'b0;
        out_ready = 1'b1;
        src_valid = '0;
        src_data  = '0;
        #1;
        chk("rst_valid", {31'b0, out_valid}, 0);
        chk("rst_data", out_data, 0);
        chk("rst_drop", {24'b0, drop_cnt}, 0);
        chk("rst_ovf", {30'b0, overflow}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;

        // Round robin from rr=0
        expect_word(1'b0, 32'hA0);
        expect_word(1'b1, 32'hB0);
        expect_word(1'b0, 32'hA1);
        expect_word(1'b1, 32'hB1);
        step(2'b11, 32'hA0, 32'hB0);
        step(2'b11, 32'hA1, 32'hB1);
        drain("rr_drain");

        // Single word latency
        expect_word(1'b0, 32'h0000_1000);
        step(2'b01, 32'h0000_1000, 32'h0);
        chk("lat_n1_valid", {31'b0, out_valid}, 0);
        @(posedge clk);
        #1;
        chk("lat_n2_valid", {31'b0, out_valid}, 1);
        chk("lat_n2_data", out_data, 32'h0000_1000);
        chk("lat_n2_id", {31'b0, out_id}, 0);
        @(posedge clk);
        #1;
        chk("lat_n3_valid", {31'b0, out_valid}, 0);

        // Backpressure: 1 in out reg, 4 buffered, 1 dropped
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) expect_word(1'b0, 32'h3000 + i);
        step(2'b01, 32'h3000, 32'h0);
        for (int i = 1; i < 6; i++) begin
            step(2'b01, 32'h3000 + i, 32'h0);
            chk("bp_hold_valid", {31'b0, out_valid}, 1);
            chk("bp_hold_data", out_data, 32'h3000);
            if (i == 4) chk("bp_cnt_before_drop", {28'b0, drop_cnt[3:0]}, 0);
        end
        chk("bp_cnt0", {28'b0, drop_cnt[3:0]}, 1);
        chk("bp_ovf0", {31'b0, overflow[0]}, 1);

        // Push on full FIFO with a pop in the same cycle is accepted
        out_ready = 1'b1;
        expect_word(1'b0, 32'h3006);
        step(2'b01, 32'h3006, 32'h0);
        chk("pp_cnt0", {28'b0, drop_cnt[3:0]}, 1);
        drain("bp_drain");

        // Clear, saturation, clear+drop, enable gating
        clear_i = 1'b1;
        step(2'b00, 32'h0, 32'h0);
        clear_i = 1'b0;
        chk("clr_cnt0", {28'b0, drop_cnt[3:0]}, 0);
        chk("clr_ovf0", {31'b0, overflow[0]}, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (i < 5) expect_word(1'b1, 32'h5000 + i);
            step(2'b10, 32'h0, 32'h5000 + i);
            if (i == 18) chk("sat_cnt1_14", {28'b0, drop_cnt[7:4]}, 14);
            if (i == 19) chk("sat_cnt1_15", {28'b0, drop_cnt[7:4]}, 15);
        end
        chk("sat_cnt1_hold", {28'b0, drop_cnt[7:4]}, 15);
        chk("sat_ovf1", {31'b0, overflow[1]}, 1);
        chk("sat_cnt0", {28'b0, drop_cnt[3:0]}, 0);
        clear_i = 1'b1;
        step(2'b00, 32'h0, 32'h0);
        clear_i = 1'b0;
        chk("clr_cnt1", {28'b0, drop_cnt[7:4]}, 0);
        chk("clr_ovf1", {31'b0, overflow[1]}, 0);
        clear_i = 1'b1;
        step(2'b10, 32'h0, 32'h5FFF);
        clear_i = 1'b0;
        chk("clrdrop_cnt1", {28'b0, drop_cnt[7:4]}, 1);
        chk("clrdrop_ovf1", {31'b0, overflow[1]}, 1);
        enable_i = 1'b0;
        step(2'b11, 32'h5DDD, 32'h5EEE);
        enable_i = 1'b1;
        chk("en_off_cnt1", {28'b0, drop_cnt[7:4]}, 1);
        chk("en_off_cnt0", {28'b0, drop_cnt[3:0]}, 0);
        out_ready = 1'b1;
        drain("sat_drain");
        @(posedge clk);
        #1;
        chk("idle_valid", {31'b0, out_valid}, 0);

        // Asynchronous reset mid-burst with a held output word
        out_ready = 1'b0;
        step(2'b01, 32'h6000, 32'h0);
        step(2'b01, 32'h6001, 32'h0);
        chk("pre_rst_valid", {31'b0, out_valid}, 1);
        #1;
        reset_i = 1'b1;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 0);
        chk("arst_data", out_data, 0);
        chk("arst_id", {31'b0, out_id}, 0);
        chk("arst_ovf", {30'b0, overflow}, 0);
        chk("arst_drop", {24'b0, drop_cnt}, 0);
        expq.delete();
        @(posedge clk);
        #1;
        reset_i   = 1'b0;
        out_ready = 1'b1;
        expect_word(1'b1, 32'h2000);
        expect_word(1'b0, 32'h2100);
        expect_word(1'b1, 32'h2101);
        step(2'b10, 32'h0, 32'h2000);
        step(2'b11, 32'h2100, 32'h2101);
        drain("post_rst_drain");
        repeat (3) @(posedge clk);
        #1;
        chk("final_valid", {31'b0, out_valid}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
